// File: rtl/sprite_sdr_arb_if.sv
// ============================================================================
// Module   : sprite_sdr_arb_if
// Purpose  : Bundle of the two requester ports and the SDRAM read channel
//            served by sprite_sdr_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_sdr_arb_if;
  logic        a_req;
  logic [24:0] a_addr;
  logic        a_rdy;
  logic [63:0] a_data;
  logic        a_busy;
  logic        b_req;
  logic [24:0] b_addr;
  logic        b_rdy;
  logic [63:0] b_data;
  logic        b_busy;
  logic        sdr_req;
  logic [24:0] sdr_addr;
  logic [63:0] sdr_data;
  logic        sdr_rdy;
  logic [7:0]  retries;

  // Environment side: requesters plus the SDRAM controller
  modport master (
    output a_req, a_addr, b_req, b_addr, sdr_data, sdr_rdy,
    input  a_rdy, a_data, a_busy, b_rdy, b_data, b_busy, sdr_req, sdr_addr, retries
  );

  // Arbiter side
  modport slave (
    input  a_req, a_addr, b_req, b_addr, sdr_data, sdr_rdy,
    output a_rdy, a_data, a_busy, b_rdy, b_data, b_busy, sdr_req, sdr_addr, retries
  );
endinterface

`default_nettype wire

// File: rtl/sprite_sdr_arb.sv
// ============================================================================
// Module   : sprite_sdr_arb
// Purpose  : Two-port (A>B, B starvation guard) arbiter for the 64-bit
//            sprite-ROM SDRAM read channel with a response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_sdr_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  wire logic           clk,
  input  wire logic           reset,
  sprite_sdr_arb_if.slave     bus
);

  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_wait   = 1'b1;
  localparam logic [7:0] c_starve    = 8'(STARVE_LIMIT);
  localparam logic [7:0] c_timeout   = 8'(TIMEOUT);
  localparam bit         c_wd_enable = (TIMEOUT != 0);

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;
  logic        r_pend_a;
  logic        r_pend_b;
  logic [24:0] r_addr_a;
  logic [24:0] r_addr_b;
  logic        r_owner_b;
  logic [7:0]  r_starve_cnt;
  logic [7:0]  r_wd_cnt;
  logic        r_sdr_req;
  logic [24:0] r_sdr_addr;
  logic        r_a_rdy;
  logic        r_b_rdy;
  logic [63:0] r_a_data;
  logic [63:0] r_b_data;
  logic [7:0]  r_retries;

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_done;
  logic        w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_grant_a || w_grant_b) w_next_state = c_st_wait;
      c_st_wait: if (w_done) w_next_state = c_st_idle;
      default:   w_next_state = c_st_idle;
    endcase
  end

  // Decisions only look at registered pending flags, so a request is never
  // granted in the cycle it arrives.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (r_pend_a && r_pend_b) begin
          if (r_starve_cnt == c_starve) w_grant_b = 1'b1;
          else                          w_grant_a = 1'b1;
        end else if (r_pend_a) begin
          w_grant_a = 1'b1;
        end else if (r_pend_b) begin
          w_grant_b = 1'b1;
        end
      end
      c_st_wait: begin
        if (bus.sdr_rdy)                              w_done    = 1'b1;
        else if (c_wd_enable && r_wd_cnt == c_timeout) w_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_a     <= 1'b0;
      r_pend_b     <= 1'b0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
      r_owner_b    <= 1'b0;
      r_starve_cnt <= '0;
      r_wd_cnt     <= '0;
      r_sdr_req    <= 1'b0;
      r_sdr_addr   <= '0;
      r_a_rdy      <= 1'b0;
      r_b_rdy      <= 1'b0;
      r_a_data     <= '0;
      r_b_data     <= '0;
      r_retries    <= '0;
    end else begin
      r_sdr_req <= w_grant_a || w_grant_b || w_timeout;
      r_a_rdy   <= w_done && !r_owner_b;
      r_b_rdy   <= w_done && r_owner_b;

      if (w_done && !r_owner_b) r_a_data <= bus.sdr_data;
      if (w_done && r_owner_b)  r_b_data <= bus.sdr_data;

      if (w_grant_a) begin
        r_sdr_addr <= r_addr_a;
        r_owner_b  <= 1'b0;
      end else if (w_grant_b) begin
        r_sdr_addr <= r_addr_b;
        r_owner_b  <= 1'b1;
      end

      if (w_grant_a || w_grant_b || w_timeout) begin
        r_wd_cnt <= '0;
      end else if (c_wd_enable && r_state == c_st_wait && !w_done) begin
        r_wd_cnt <= r_wd_cnt + 8'd1;
      end

      if (w_timeout && r_retries != 8'hFF) r_retries <= r_retries + 8'd1;

      // A new pulse beats the grant-clear so a request landing on its own
      // grant cycle is queued rather than lost.
      if (bus.a_req) begin
        r_pend_a <= 1'b1;
        r_addr_a <= bus.a_addr;
      end else if (w_grant_a) begin
        r_pend_a <= 1'b0;
      end
      if (bus.b_req) begin
        r_pend_b <= 1'b1;
        r_addr_b <= bus.b_addr;
      end else if (w_grant_b) begin
        r_pend_b <= 1'b0;
      end

      if (!r_pend_b || w_grant_b) begin
        r_starve_cnt <= '0;
      end else if (w_grant_a && r_starve_cnt != c_starve) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end

  assign bus.sdr_req  = r_sdr_req;
  assign bus.sdr_addr = r_sdr_addr;
  assign bus.a_rdy    = r_a_rdy;
  assign bus.b_rdy    = r_b_rdy;
  assign bus.a_data   = r_a_data;
  assign bus.b_data   = r_b_data;
  assign bus.retries  = r_retries;
  assign bus.a_busy   = r_pend_a || (r_state == c_st_wait && !r_owner_b);
  assign bus.b_busy   = r_pend_b || (r_state == c_st_wait && r_owner_b);

endmodule

`default_nettype wire

// File: tb/tb_sprite_sdr_arb.sv
// ============================================================================
// Module   : tb_sprite_sdr_arb
// Purpose  : Scoreboard bench for sprite_sdr_arb with a small SDRAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_sdr_arb;

  logic clk;
  logic reset;
  sprite_sdr_arb_if bus();

  sprite_sdr_arb #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cd       = 0;
  int mdl_delay = 5;
  bit kick     = 1'b0;
  bit saw_req  = 1'b0;
  bit track_b  = 1'b0;
  int n_b_gap  = 0;
  int n_unexp  = 0;
  int n_a_rdy  = 0;
  int n_b_rdy  = 0;
  int n_sdr_req = 0;
  int last_req_cyc   = 0;
  int last_a_rdy_cyc = 0;

  logic [63:0] exp_a[$];
  logic [63:0] exp_b[$];
  logic [24:0] exp_sdr[$];

  // Model ROM content; chosen so address 0x0100040 reads 0x1122334455667788.
  function automatic logic [63:0] mem_data(input logic [24:0] a);
    return 64'h1122334455667788 ^ {39'd0, a ^ 25'h0100040};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [63:0] e;
    logic [24:0] ea;
    @(posedge clk);
    #1;
    cyc++;
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    saw_req   = 1'b0;
    if (bus.a_rdy && bus.b_rdy) n_unexp++;
    if (track_b) begin
      if (bus.b_rdy)        track_b = 1'b0;
      else if (!bus.b_busy) n_b_gap++;
    end
    if (bus.a_rdy) begin
      n_a_rdy++;
      last_a_rdy_cyc = cyc;
      if (exp_a.size() == 0) n_unexp++;
      else begin
        e = exp_a.pop_front();
        chk("a_data", bus.a_data, e);
      end
    end
    if (bus.b_rdy) begin
      n_b_rdy++;
      if (exp_b.size() == 0) n_unexp++;
      else begin
        e = exp_b.pop_front();
        chk("b_data", bus.b_data, e);
      end
    end
    bus.sdr_rdy = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        bus.sdr_rdy  = 1'b1;
        bus.sdr_data = mem_data(bus.sdr_addr);
      end
    end
    if (kick) begin
      bus.sdr_rdy  = 1'b1;
      bus.sdr_data = mem_data(bus.sdr_addr);
      kick = 1'b0;
    end
    if (bus.sdr_req) begin
      saw_req = 1'b1;
      n_sdr_req++;
      last_req_cyc = cyc;
      if (exp_sdr.size() == 0) n_unexp++;
      else begin
        ea = exp_sdr.pop_front();
        chk("sdr_addr", {39'd0, bus.sdr_addr}, {39'd0, ea});
      end
      cd = mdl_delay;
    end
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!saw_req && n < budget);
    chk("sdr_req_seen", {63'd0, saw_req}, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a.size() + exp_b.size() + exp_sdr.size() != 0 || bus.a_busy ||
            bus.b_busy || cd != 0) && n < 300) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("drain_left", 64'(exp_a.size() + exp_b.size() + exp_sdr.size()), 64'd0);
  endtask

  task automatic req_a(input logic [24:0] a);
    bus.a_req  = 1'b1;
    bus.a_addr = a;
  endtask

  task automatic req_b(input logic [24:0] a);
    bus.b_req  = 1'b1;
    bus.b_addr = a;
  endtask

  initial begin
    int t0;
    int c0;
    int c1;
    int c2;
    int na;
    int nb;
    int nr;
    bus.a_req = 1'b0; bus.a_addr = '0;
    bus.b_req = 1'b0; bus.b_addr = '0;
    bus.sdr_rdy = 1'b0; bus.sdr_data = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ctl", {59'd0, bus.sdr_req, bus.a_rdy, bus.b_rdy, bus.a_busy, bus.b_busy}, 64'd0);
    chk("rst_sdr_addr", {39'd0, bus.sdr_addr}, 64'd0);
    chk("rst_a_data", bus.a_data, 64'd0);
    chk("rst_b_data", bus.b_data, 64'd0);
    chk("rst_retries", {56'd0, bus.retries}, 64'd0);

    // Single A read
    na = n_a_rdy;
    t0 = cyc;
    req_a(25'h0100040);
    exp_sdr.push_back(25'h0100040);
    exp_a.push_back(64'h1122334455667788);
    drain();
    chk("a_req_latency", 64'(last_req_cyc - t0), 64'd2);
    chk("a_rdy_latency", 64'(last_a_rdy_cyc - last_req_cyc), 64'd6);
    chk("a_rdy_pulses", 64'(n_a_rdy - na), 64'd1);
    chk("a_busy_after", {63'd0, bus.a_busy}, 64'd0);
    chk("a_data_held", bus.a_data, 64'h1122334455667788);

    // Simultaneous A+B: A first, B one cycle after a_rdy
    req_a(25'h10);
    req_b(25'h20);
    track_b = 1'b1;
    n_b_gap = 0;
    exp_sdr.push_back(25'h10);
    exp_sdr.push_back(25'h20);
    exp_a.push_back(mem_data(25'h10));
    exp_b.push_back(mem_data(25'h20));
    drain();
    chk("b_after_a_rdy", 64'(last_req_cyc - last_a_rdy_cyc), 64'd1);
    chk("b_busy_hold", 64'(n_b_gap), 64'd0);

    // Starvation: four A grants while B waits, then B, then the last A
    req_a(25'h100);
    req_b(25'h0B00);
    exp_sdr.push_back(25'h100);
    exp_a.push_back(mem_data(25'h100));
    exp_b.push_back(mem_data(25'h0B00));
    for (int k = 0; k < 4; k++) begin
      wait_req(40);
      req_a(25'h100 + 25'((k + 1) * 8));
      if (k == 3) exp_sdr.push_back(25'h0B00);
      exp_sdr.push_back(25'h100 + 25'((k + 1) * 8));
      exp_a.push_back(mem_data(25'h100 + 25'((k + 1) * 8)));
    end
    drain();
    // Counter cleared: a fresh simultaneous pair goes to A first again
    req_a(25'h180);
    req_b(25'h0C00);
    exp_sdr.push_back(25'h180);
    exp_sdr.push_back(25'h0C00);
    exp_a.push_back(mem_data(25'h180));
    exp_b.push_back(mem_data(25'h0C00));
    drain();

    // Overwrite of a pending B request while A is in flight
    nb = n_b_rdy;
    req_a(25'h200);
    exp_sdr.push_back(25'h200);
    exp_a.push_back(mem_data(25'h200));
    wait_req(10);
    req_b(25'h30);
    tick();
    req_b(25'h40);
    exp_sdr.push_back(25'h40);
    exp_b.push_back(mem_data(25'h40));
    drain();
    chk("b_rdy_single", 64'(n_b_rdy - nb), 64'd1);

    // Watchdog: no response, re-issue every 9 WAIT cycles
    mdl_delay = 0;
    req_a(25'h777);
    for (int k = 0; k < 3; k++) exp_sdr.push_back(25'h777);
    wait_req(10);
    c0 = last_req_cyc;
    wait_req(20);
    c1 = last_req_cyc;
    wait_req(20);
    c2 = last_req_cyc;
    chk("wd_period_1", 64'(c1 - c0), 64'd9);
    chk("wd_period_2", 64'(c2 - c1), 64'd9);
    chk("wd_retries", {56'd0, bus.retries}, 64'd2);
    exp_a.push_back(mem_data(25'h777));
    kick = 1'b1;
    drain();
    chk("wd_retries_after", {56'd0, bus.retries}, 64'd2);

    // Spurious sdr_rdy in IDLE
    na = n_a_rdy;
    nb = n_b_rdy;
    kick = 1'b1;
    tick();
    tick();
    tick();
    chk("spurious_rdy", 64'((n_a_rdy - na) + (n_b_rdy - nb)), 64'd0);

    // Completion arriving in the timeout cycle wins over a re-issue
    nr = n_sdr_req;
    req_a(25'h888);
    exp_sdr.push_back(25'h888);
    exp_a.push_back(mem_data(25'h888));
    wait_req(10);
    for (int k = 0; k < 7; k++) tick();
    kick = 1'b1;
    drain();
    chk("tie_no_reissue", 64'(n_sdr_req - nr), 64'd1);
    chk("tie_retries", {56'd0, bus.retries}, 64'd2);

    // Reset during WAIT: B in flight, A pending
    na = n_a_rdy;
    nb = n_b_rdy;
    req_b(25'h50);
    exp_sdr.push_back(25'h50);
    wait_req(10);
    req_a(25'h60);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cd = 0;
    chk("rst2_ctl", {59'd0, bus.sdr_req, bus.a_rdy, bus.b_rdy, bus.a_busy, bus.b_busy}, 64'd0);
    chk("rst2_sdr_addr", {39'd0, bus.sdr_addr}, 64'd0);
    chk("rst2_a_data", bus.a_data, 64'd0);
    chk("rst2_b_data", bus.b_data, 64'd0);
    chk("rst2_retries", {56'd0, bus.retries}, 64'd0);
    kick = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("rst2_no_rdy", 64'((n_a_rdy - na) + (n_b_rdy - nb)), 64'd0);
    mdl_delay = 5;
    drain();

    chk("unexpected_events", 64'(n_unexp), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
